seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed eight-digit seven-segment driver that sits directly downstream of the CPU datapath on the board top. It drives the board pins `o_seg`/`o_sel`. It accepts a 32-bit display word through a valid/ready handshake and holds it in a pending slot. The word is committed to the visible shadow register only at a frame boundary, so a display update never tears mid-scan. Each nibble is shown as one hex digit, with all board pins active-low.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range 2..2^20.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-low.
- `i_valid`, input, 1: `i_data` is offered this cycle.
- `i_data`, input, 32: display word. Nibble k drives digit k; digit 0 is rightmost.
- `o_ready`, output, 1: pending slot empty; a word is accepted when `i_valid && o_ready`.
- `o_seg`, output, 8: segment bits `{dp,g,f,e,d,c,b,a}`, active-low, registered.
- `o_sel`, output, 8: digit enables; `o_sel[k]` is low for digit k, one-cold, registered.

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1 and then wraps.
- `tick` is asserted when `div_cnt == SCAN_DIV-1`.
- Digit index `idx` is 3 bits and increments on `tick`, wrapping 7→0.
- Frame boundary: a `tick` while `idx == 7`.
  - If pending is valid: shadow ← pending, and pending is cleared, on that same edge.
  - The outputs for the new digit 0 are then computed from the new shadow value on that same edge.
- Handshake:
  - `o_ready = !pend_valid`, registered.
  - On accept, pending ← `i_data` and `pend_valid` ← 1.
  - `i_valid` while `o_ready` is low is ignored; the data is not captured and there is no error.
  - A frame-boundary clear and a new offer in the same cycle: the offer is not accepted, because `o_ready` was low. `o_ready` rises on the clear edge and the offer is accepted on the next cycle.
  - Only one word is buffered. A later word overwrites nothing until the slot empties.
- Decode for each hex nibble (`dp` always off): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- Reset values:
  - `o_seg = 8'hFF`, `o_sel = 8'hFF`, `o_ready = 1` (registered, so it reads 1 on the first cycle after reset releases).
  - `idx = 7`, `div_cnt = 0`, shadow = 0, `pend_valid = 0`.
- Reset asserted mid-frame or mid-handshake: everything returns to the reset values on that edge, and any pending word is discarded.

## Timing
- `o_sel`/`o_seg` change only on a `tick` edge. Each digit is held for exactly SCAN_DIV cycles, and one frame is 8·SCAN_DIV cycles.
- First tick after reset: the edge at the end of cycle SCAN_DIV-1 after reset releases. It enables digit 0 from the shadow, which is 0.
- Accept-to-visible latency: at most 8·SCAN_DIV + 1 cycles and at least 1 cycle (accept immediately before a frame boundary).
- `o_ready` falls on the accept edge and rises on the frame-boundary edge.

## Configuration
- Macro: `SEG7_LEADING_ZERO_BLANK_EN`.
- Defined: digits above the highest nonzero nibble of the shadow are blanked (`o_seg = 8'hFF` and `o_sel[k] = 1` for that slot). Digit 0 is never blanked.
- Undefined: all eight digits are always lit.
- Scan timing is identical in both builds.

## Structure
- Package `seg7_pkg`:
  - `SEG_BLANK = 8'hFF` and `SEL_NONE = 8'hFF`.
  - The 16-entry hex→segment constant array.
  - The `seg_t`/`sel_t` 8-bit typedefs.
- Sub-module `seg7_hex_decoder`: combinational, 4-bit nibble in, `seg_t` out, with no state.
- The top module holds the prescaler, index, pending/shadow registers, handshake and output registers.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset release with no input → `o_sel`/`o_seg` = FF/FF for 3 cycles; then `o_sel=FE, o_seg=C0`; `o_sel` walks FD, FB … 7F every 4 cycles, with `o_seg=C0` throughout.
- Offer `32'h89ABCDEF` mid-frame → `o_ready` drops the next cycle. At the next boundary, digits 0..7 show 8E, 86, A1, C6, 83, 88, 90, 80, and `o_ready` rises on that boundary edge.
- Two back-to-back offers, `32'h11111111` then `32'h22222222` → only the first is accepted. The second is re-offered after `o_ready` rises and becomes visible one frame later (all digits A4).
- Offer held high, timed so the frame boundary falls on an offer cycle → acceptance occurs exactly one cycle after the boundary edge, with no loss and no duplicate capture.
- With `SEG7_LEADING_ZERO_BLANK_EN`, load `32'h00000120` → digits 0..2 show C0, A4, F9; digits 3..7 have `o_sel` all 1s and `o_seg=FF`. Without the macro, digits 3..7 show C0.
- Assert `rst` low during digit 5 with a word pending → outputs become FF/FF and `o_ready=1` on that edge. After release the display shows 0s; the pending word is never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and helpers for the seven-segment scan driver
package seg7_pkg;

    typedef logic [7:0] seg_t;
    typedef logic [7:0] sel_t;

    localparam seg_t SEG_BLANK = 8'hFF;
    localparam sel_t SEL_NONE  = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam seg_t HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Index of the most significant nonzero nibble; 0 when the word is all zero
    function automatic logic [2:0] lead_digit(input logic [31:0] word);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (word[4*k +: 4] != 4'h0) r = 3'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex nibble to active-low segment pattern
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - eight-digit multiplexed display driver; optional SEG7_LEADING_ZERO_BLANK_EN
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic        o_ready,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    localparam int             DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [31:0]   shadow;
    logic [31:0]   shadow_next;
    logic [31:0]   pend_data;
    logic          pend_valid;
    logic          tick;
    logic          boundary;
    logic          commit;
    logic          accept;
    logic [3:0]    nibble;
    seg_t          dec_seg;
    seg_t          seg_next;
    sel_t          sel_next;

    assign pend_valid  = !o_ready;
    assign tick        = (div_cnt == DIV_LAST);
    assign idx_next    = idx + 3'd1;
    assign boundary    = tick && (idx == 3'd7);
    assign commit      = boundary && pend_valid;
    assign accept      = i_valid && o_ready;

    // The digit shown after a boundary must come from the freshly committed word
    assign shadow_next = commit ? pend_data : shadow;
    assign nibble      = shadow_next[{idx_next, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_next = dec_seg;
        sel_next = ~(8'b1 << idx_next);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx_next > lead_digit(shadow_next)) begin
            seg_next = SEG_BLANK;
            sel_next = SEL_NONE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt   <= '0;
            idx       <= 3'd7;
            shadow    <= '0;
            pend_data <= '0;
            o_ready   <= 1'b1;
            o_seg     <= SEG_BLANK;
            o_sel     <= SEL_NONE;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            shadow  <= shadow_next;
            if (tick) begin
                idx   <= idx_next;
                o_seg <= seg_next;
                o_sel <= sel_next;
            end
            // A commit and an accept never coincide: accept needs the slot already empty
            if (commit) begin
                o_ready <= 1'b1;
            end else if (accept) begin
                o_ready   <= 1'b0;
                pend_data <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver with SCAN_DIV=4
module tb_seg7_scan_driver;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        o_ready;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: n = edges since reset, word currently shown, one-deep slot
    int          n = 0;
    logic [31:0] shown = 32'h0;
    logic [31:0] pend = 32'h0;
    logic        m_ready = 1'b1;
    logic [7:0]  hex_seg [16];

    typedef struct {
        logic [3:0] nib;
        logic [7:0] seg;
    } dec_vec_t;

    dec_vec_t dec_tab [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_seg   (o_seg),
        .o_sel   (o_sel)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    function automatic int lead(input logic [31:0] w);
        int r = 0;
        for (int k = 0; k < 8; k++) if (w[4*k +: 4] != 4'h0) r = k;
        return r;
    endfunction
`endif

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_expect(output logic [7:0] es, output logic [7:0] esel);
        int slot = n / S;
        int d;
        if (slot == 0) begin
            es   = 8'hFF;
            esel = 8'hFF;
        end else begin
            d    = (slot - 1) % 8;
            es   = hex_seg[shown[4*d +: 4]];
            esel = ~(8'b1 << d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (d > lead(shown)) begin
                es   = 8'hFF;
                esel = 8'hFF;
            end
`endif
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d);
        logic       rb;
        logic [7:0] es, esel;
        i_valid = v;
        i_data  = d;
        @(posedge clk);
        rb = m_ready;
        if (!rst) begin
            n = 0;
            shown = 32'h0;
            m_ready = 1'b1;
        end else begin
            n++;
            if (rb && v) begin
                pend = d;
                m_ready = 1'b0;
            end
            if ((n % (8*S)) == S && !rb) begin
                shown = pend;
                m_ready = 1'b1;
            end
        end
        #1;
        model_expect(es, esel);
        check("model_seg", o_seg, es);
        check("model_sel", o_sel, esel);
        check("model_ready", {7'b0, o_ready}, {7'b0, m_ready});
    endtask

    task automatic wait_ready(input logic v, input logic [31:0] d);
        int k = 0;
        while (!o_ready && k < 12*S) begin
            step(v, d);
            k++;
        end
        check("ready_timeout", {7'b0, o_ready}, 8'h01);
    endtask

    task automatic wait_sel(input logic [7:0] target);
        int k = 0;
        while (o_sel !== target && k < 12*S) begin
            step(1'b0, 32'h0);
            k++;
        end
        check("sel_timeout", o_sel, target);
    endtask

    initial begin
        logic [7:0] exp89 [8];
        logic [7:0] e;
        hex_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        for (int i = 0; i < 16; i++) begin
            dec_tab[i].nib = 4'(i);
            dec_tab[i].seg = hex_seg[i];
        end
        exp89 = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};

        rst = 1'b0;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        rst = 1'b1;

        // Reset release: blank, then digit 0..7 of zero word
        for (int i = 0; i < S - 1; i++) step(1'b0, 32'h0);
        check("pre_tick_sel", o_sel, 8'hFF);
        step(1'b0, 32'h0);
        check("first_digit_sel", o_sel, 8'hFE);
        check("first_digit_seg", o_seg, 8'hC0);
        for (int k = 1; k < 8; k++) begin
            repeat (S) step(1'b0, 32'h0);
            e = 8'hFF ^ (8'h01 << k);
            check("walk_sel", o_sel, e);
            check("walk_seg", o_seg, 8'hC0);
        end

        // Mid-frame offer, visible at the next boundary
        repeat (S/2) step(1'b0, 32'h0);
        step(1'b1, 32'h89ABCDEF);
        check("accept_ready_low", {7'b0, o_ready}, 8'h00);
        wait_ready(1'b0, 32'h0);
        check("commit_sel", o_sel, 8'hFE);
        check("digit_89_0", o_seg, exp89[0]);
        for (int d = 1; d < 8; d++) begin
            repeat (S) step(1'b0, 32'h0);
            check("digit_89", o_seg, exp89[d]);
        end

        // Back-to-back offers; second held until the slot frees at a boundary
        step(1'b1, 32'h11111111);
        step(1'b1, 32'h22222222);
        check("second_ignored", {7'b0, o_ready}, 8'h00);
        wait_ready(1'b1, 32'h22222222);
        check("first_word_seg", o_seg, 8'hF9);
        step(1'b1, 32'h22222222);
        check("held_accept_next_cycle", {7'b0, o_ready}, 8'h00);
        wait_ready(1'b0, 32'h0);
        check("second_word_seg", o_seg, 8'hA4);

        // Leading-zero behaviour
        step(1'b1, 32'h00000120);
        wait_ready(1'b0, 32'h0);
        for (int d = 0; d < 8; d++) begin
            if (d > 0) repeat (S) step(1'b0, 32'h0);
            e = (d == 0) ? 8'hC0 : (d == 1) ? 8'hA4 : (d == 2) ? 8'hF9 : 8'hC0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (d > 2) e = 8'hFF;
            check("blank_sel", o_sel, (d > 2) ? 8'hFF : (8'hFF ^ (8'h01 << d)));
`else
            check("blank_sel", o_sel, 8'hFF ^ (8'h01 << d));
`endif
            check("blank_seg", o_seg, e);
        end

        // Reset during digit 5 with a word pending
        wait_sel(8'hDF);
        step(1'b1, 32'h55555555);
        check("pend_before_reset", {7'b0, o_ready}, 8'h00);
        rst = 1'b0;
        step(1'b0, 32'h0);
        check("reset_seg", o_seg, 8'hFF);
        check("reset_sel", o_sel, 8'hFF);
        check("reset_ready", {7'b0, o_ready}, 8'h01);
        rst = 1'b1;
        repeat (9*S) step(1'b0, 32'h0);
        check("post_reset_seg", o_seg, 8'hC0);

        // Table-driven decode of every hex digit
        for (int i = 0; i < 16; i++) begin
            wait_ready(1'b0, 32'h0);
            step(1'b1, {8{dec_tab[i].nib}});
            wait_ready(1'b0, 32'h0);
            check("decode_sel", o_sel, 8'hFE);
            check("decode_seg", o_seg, dec_tab[i].seg);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) != 0);
            step($urandom_range(0, 3) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
